stride_prefetcher: RTL and testbench

STRIDE_PREFETCHER -- requirements
Module: stride_prefetcher

---
 rtl/stride_prefetcher.sv | 164 ++++++++++++++++
 tb/tb_stride_prefetcher.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stride_prefetcher.sv
// Stride prefetcher: learns a constant line stride from upper-level misses and,
// once confident, issues a burst of DEGREE line-aligned prefetch requests.
// Optional duplicate filter compiled in with `define PF_DUP_FILTER_EN.
module stride_prefetcher #(
   parameter int unsigned BLOCK_BITS  = 6,
   parameter int unsigned DEGREE      = 2,
   parameter int unsigned CONF_THRESH = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [63:0] up_address_i,
   input  logic        up_miss_i,
   input  logic        up_valid_i,
   input  logic        lo_ready_i,
   output logic [63:0] lo_prefetch_address_o,
   output logic        lo_prefetch_valid_o,
   output logic        pf_busy_o,
   output logic [31:0] pf_issued_o
);

   typedef enum logic {StIdle, StIssue} state_e;

   state_e      state_q, state_d;
   logic        hist_valid_q, hist_valid_d;
   logic [63:0] last_line_q, last_line_d;
   logic [63:0] stride_q, stride_d;
   logic [1:0]  conf_q, conf_d;
   logic [63:0] cand_q, cand_d;
   logic [2:0]  k_q, k_d;
   logic [31:0] issued_q, issued_d;

   logic [63:0] line;
   logic [63:0] delta;
   logic        trig;
   logic        filtered;
   logic        handshake;

`ifdef PF_DUP_FILTER_EN
   logic [63:0] ring_q [4];
   logic [63:0] ring_d [4];
   logic [3:0]  ring_v_q, ring_v_d;
   logic [1:0]  ptr_q, ptr_d;
`endif

   assign line  = up_address_i >> BLOCK_BITS;
   assign delta = line - last_line_q;

   // Stride training and trigger detection; runs regardless of FSM state.
   always_comb begin
      hist_valid_d = hist_valid_q;
      last_line_d  = last_line_q;
      stride_d     = stride_q;
      conf_d       = conf_q;
      trig         = 1'b0;
      if (up_valid_i && up_miss_i) begin
         if (!hist_valid_q) begin
            hist_valid_d = 1'b1;
            last_line_d  = line;
            stride_d     = '0;
            conf_d       = '0;
         end else if (delta != '0) begin
            last_line_d = line;
            if (delta == stride_q) begin
               conf_d = (conf_q == 2'd3) ? 2'd3 : conf_q + 2'd1;
            end else begin
               stride_d = delta;
               conf_d   = '0;
            end
            trig = ({30'd0, conf_d} >= CONF_THRESH);
         end
      end
   end

   // Candidate filter: skip lines already handed to the lower level recently.
   always_comb begin
      filtered = 1'b0;
`ifdef PF_DUP_FILTER_EN
      if (state_q == StIssue) begin
         for (int i = 0; i < 4; i++) begin
            if (ring_v_q[i] && (ring_q[i] == cand_q)) filtered = 1'b1;
         end
      end
`endif
   end

   assign lo_prefetch_valid_o   = (state_q == StIssue) && !filtered;
   assign lo_prefetch_address_o = (state_q == StIssue) ? (cand_q << BLOCK_BITS) : '0;
   assign pf_busy_o             = (state_q == StIssue);
   assign pf_issued_o           = issued_q;
   assign handshake             = lo_prefetch_valid_o && lo_ready_i;

   // Burst FSM: walks DEGREE candidates, one per handshake or filtered skip.
   always_comb begin
      state_d  = state_q;
      cand_d   = cand_q;
      k_d      = k_q;
      issued_d = issued_q;
`ifdef PF_DUP_FILTER_EN
      ring_d   = ring_q;
      ring_v_d = ring_v_q;
      ptr_d    = ptr_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (trig) begin
               state_d = StIssue;
               cand_d  = line + stride_d;
               k_d     = 3'd1;
            end
         end
         StIssue: begin
            // Conditions arising here are dropped; the burst is not restarted.
            if (handshake || filtered) begin
               cand_d = cand_q + stride_q;
               if (k_q == 3'(DEGREE)) state_d = StIdle;
               else                   k_d     = k_q + 3'd1;
            end
            if (handshake) begin
               issued_d = issued_q + 32'd1;
`ifdef PF_DUP_FILTER_EN
               ring_d[ptr_q]   = cand_q;
               ring_v_d[ptr_q] = 1'b1;
               ptr_d           = ptr_q + 2'd1;
`endif
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers with synchronous reset; reset discards any same-cycle event.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= StIdle;
         hist_valid_q <= 1'b0;
         last_line_q  <= '0;
         stride_q     <= '0;
         conf_q       <= '0;
         cand_q       <= '0;
         k_q          <= '0;
         issued_q     <= '0;
`ifdef PF_DUP_FILTER_EN
         for (int i = 0; i < 4; i++) ring_q[i] <= '0;
         ring_v_q <= '0;
         ptr_q    <= '0;
`endif
      end else begin
         state_q      <= state_d;
         hist_valid_q <= hist_valid_d;
         last_line_q  <= last_line_d;
         stride_q     <= stride_d;
         conf_q       <= conf_d;
         cand_q       <= cand_d;
         k_q          <= k_d;
         issued_q     <= issued_d;
`ifdef PF_DUP_FILTER_EN
         ring_q   <= ring_d;
         ring_v_q <= ring_v_d;
         ptr_q    <= ptr_d;
`endif
      end
   end

endmodule

// File: tb/tb_stride_prefetcher.sv
// Scoreboard bench for stride_prefetcher: a behavioural model predicts every
// cycle's outputs into a queue; a monitor pops and compares at the falling edge.
module tb_stride_prefetcher;

   localparam int unsigned BB  = 6;
   localparam int unsigned DEG = 2;
   localparam int unsigned TH  = 2;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic [63:0] up_address_i = '0;
   logic        up_miss_i = 1'b0;
   logic        up_valid_i = 1'b0;
   logic        lo_ready_i = 1'b0;
   logic [63:0] lo_prefetch_address_o;
   logic        lo_prefetch_valid_o;
   logic        pf_busy_o;
   logic [31:0] pf_issued_o;

   stride_prefetcher #(
      .BLOCK_BITS (BB),
      .DEGREE     (DEG),
      .CONF_THRESH(TH)
   ) dut (
      .clk_i                (clk),
      .rst_i                (rst_i),
      .up_address_i         (up_address_i),
      .up_miss_i            (up_miss_i),
      .up_valid_i           (up_valid_i),
      .lo_ready_i           (lo_ready_i),
      .lo_prefetch_address_o(lo_prefetch_address_o),
      .lo_prefetch_valid_o  (lo_prefetch_valid_o),
      .pf_busy_o            (pf_busy_o),
      .pf_issued_o          (pf_issued_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [63:0] a;
      logic        b;
      logic [31:0] n;
   } exp_t;

   exp_t        sb[$];
   logic [63:0] hs_log[$];
   int          checks = 0;
   int          errors = 0;

   // Reference model: plain variables following the training/burst rules.
   bit              m_busy;
   bit              m_hist;
   longint unsigned m_last, m_stride, m_cand;
   int              m_conf, m_k;
   logic [31:0]     m_cnt;
   longint unsigned m_recent[$];  // most recent (up to 4) issued lines

   task automatic m_reset();
      m_busy = 0; m_hist = 0; m_last = 0; m_stride = 0; m_cand = 0;
      m_conf = 0; m_k = 0; m_cnt = 0;
      m_recent.delete();
   endtask

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus: drive, predict this cycle's outputs, advance model.
   task automatic cycle(bit r, bit v, bit m, logic [63:0] a, bit rd);
      exp_t            e;
      bit              filt, trig;
      longint unsigned line, delta, old_stride;
      @(posedge clk);
      #1;
      rst_i = r; up_valid_i = v; up_miss_i = m; up_address_i = a; lo_ready_i = rd;
      filt = 0;
`ifdef PF_DUP_FILTER_EN
      if (m_busy) foreach (m_recent[i]) if (m_recent[i] == m_cand) filt = 1;
`endif
      e.v = m_busy && !filt;
      e.a = m_busy ? (m_cand << BB) : 64'd0;
      e.b = m_busy;
      e.n = m_cnt;
      sb.push_back(e);
      if (r) begin
         m_reset();
         return;
      end
      old_stride = m_stride;
      trig = 0;
      line = a >> BB;
      if (v && m) begin
         if (!m_hist) begin
            m_hist = 1; m_last = line; m_stride = 0; m_conf = 0;
         end else begin
            delta = line - m_last;
            if (delta != 0) begin
               if (delta == m_stride) m_conf = (m_conf < 3) ? m_conf + 1 : 3;
               else begin
                  m_stride = delta; m_conf = 0;
               end
               m_last = line;
               trig = (m_conf >= int'(TH));
            end
         end
      end
      if (m_busy) begin
         if ((e.v && rd) || filt) begin
            if (e.v && rd) begin
               m_cnt++;
               m_recent.push_back(m_cand);
               if (m_recent.size() > 4) void'(m_recent.pop_front());
            end
            m_cand += old_stride;
            if (m_k == int'(DEG)) m_busy = 0;
            else m_k++;
         end
      end else if (trig) begin
         m_busy = 1; m_cand = line + m_stride; m_k = 1;
      end
   endtask

   task automatic miss(logic [63:0] a);
      cycle(0, 1, 1, a, 1);
   endtask

   task automatic idle(int n, bit rd);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 64'h0, rd);
   endtask

   task automatic do_reset();
      cycle(1, 0, 0, 64'h0, 0);
      cycle(1, 0, 0, 64'h0, 0);
   endtask

   // Let the monitor consume the last pushed expectation.
   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   // Monitor: compare every presented cycle against the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("valid", {63'd0, lo_prefetch_valid_o}, {63'd0, e.v});
            chk("address", lo_prefetch_address_o, e.a);
            chk("busy", {63'd0, pf_busy_o}, {63'd0, e.b});
            chk("issued", {32'd0, pf_issued_o}, {32'd0, e.n});
            if (lo_prefetch_valid_o && lo_ready_i) hs_log.push_back(lo_prefetch_address_o);
         end
      end
   end

   initial begin
      longint unsigned p_line, p_stride;
      int              sel;
      m_reset();

      // Basic +1 line stride, back-to-back issue.
      do_reset();
      hs_log.delete();
      miss(64'h1000); miss(64'h1040); miss(64'h1080); miss(64'h10C0);
      idle(4, 1);
      settle();
      chk("basic_count", {32'd0, pf_issued_o}, 64'd2);
      chk("basic_nhs", 64'(hs_log.size()), 64'd2);
      if (hs_log.size() == 2) begin
         chk("basic_hs0", hs_log[0], 64'h1100);
         chk("basic_hs1", hs_log[1], 64'h1140);
      end
      chk("basic_idle", {63'd0, pf_busy_o}, 64'd0);

      // Re-trigger on the next line; duplicate filter decides what is re-issued.
      hs_log.delete();
      miss(64'h1100);
      idle(4, 1);
      settle();
`ifdef PF_DUP_FILTER_EN
      chk("dup_count", {32'd0, pf_issued_o}, 64'd3);
      chk("dup_nhs", 64'(hs_log.size()), 64'd1);
      if (hs_log.size() == 1) chk("dup_hs0", hs_log[0], 64'h1180);
`else
      chk("dup_count", {32'd0, pf_issued_o}, 64'd4);
      chk("dup_nhs", 64'(hs_log.size()), 64'd2);
      if (hs_log.size() == 2) begin
         chk("dup_hs0", hs_log[0], 64'h1140);
         chk("dup_hs1", hs_log[1], 64'h1180);
      end
`endif

      // Backpressure: first candidate held for 5 cycles.
      do_reset();
      hs_log.delete();
      miss(64'h1000); miss(64'h1040); miss(64'h1080); miss(64'h10C0);
      idle(5, 0);
      idle(4, 1);
      settle();
      chk("bp_count", {32'd0, pf_issued_o}, 64'd2);
      chk("bp_nhs", 64'(hs_log.size()), 64'd2);
      if (hs_log.size() == 2) begin
         chk("bp_hs0", hs_log[0], 64'h1100);
         chk("bp_hs1", hs_log[1], 64'h1140);
      end

      // Negative stride.
      do_reset();
      hs_log.delete();
      miss(64'h2000); miss(64'h1F80); miss(64'h1F00); miss(64'h1E80);
      idle(4, 1);
      settle();
      chk("neg_nhs", 64'(hs_log.size()), 64'd2);
      if (hs_log.size() == 2) begin
         chk("neg_hs0", hs_log[0], 64'h1E00);
         chk("neg_hs1", hs_log[1], 64'h1D80);
      end

      // Same-line miss and hits do not train.
      do_reset();
      hs_log.delete();
      miss(64'h1000); miss(64'h1008);
      cycle(0, 1, 0, 64'h1040, 1); cycle(0, 1, 0, 64'h1080, 1);
      idle(3, 1);
      settle();
      chk("hits_nhs", 64'(hs_log.size()), 64'd0);
      chk("hits_busy", {63'd0, pf_busy_o}, 64'd0);

      // Reset mid-burst with ready high: pending request not counted.
      do_reset();
      hs_log.delete();
      miss(64'h1000); miss(64'h1040); miss(64'h1080); miss(64'h10C0);
      cycle(1, 0, 0, 64'h0, 1);
      idle(3, 1);
      settle();
      chk("rst_count", {32'd0, pf_issued_o}, 64'd0);
      chk("rst_valid", {63'd0, lo_prefetch_valid_o}, 64'd0);

      // Randomised traffic: strided miss streams mixed with noise and backpressure.
      do_reset();
      p_line = 64'($urandom);
      p_stride = 1;
      for (int i = 0; i < 4000; i++) begin
         sel = int'($urandom_range(0, 99));
         if (sel == 0) begin
            cycle(1, $urandom_range(0, 1), 1, {$urandom, $urandom}, $urandom_range(0, 1));
         end else if (sel < 45) begin
            cycle(0, 1, 1, (p_line << BB) | 64'($urandom_range(0, 63)),
                  $urandom_range(0, 9) < 7);
            p_line += p_stride;
         end else if (sel < 50) begin
            p_line = 64'($urandom);
            case ($urandom_range(0, 4))
               0: p_stride = 1;
               1: p_stride = 2;
               2: p_stride = -1;
               3: p_stride = -3;
               default: p_stride = 64'($urandom_range(4, 40));
            endcase
         end else if (sel < 60) begin
            cycle(0, 1, 0, {$urandom, $urandom}, $urandom_range(0, 9) < 7);
         end else if (sel < 63) begin
            cycle(0, 1, 1, {$urandom, $urandom}, $urandom_range(0, 9) < 7);
         end else begin
            cycle(0, $urandom_range(0, 1), 0, {$urandom, $urandom}, $urandom_range(0, 9) < 7);
         end
      end
      settle();
      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
